// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Brief    : valid/ready front end for a synchronous single-port SRAM with
//            registered strobes and a one-cycle bus turnaround after reads.
//            Optional build macro SRAM_CTRL_STATS_EN adds saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] mem_a,
  output logic          mem_cs,
  output logic          mem_we,
  output logic          mem_oe,
  inout  wire  [DW-1:0] mem_d
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [15:0]   wr_count,
  output logic [15:0]   rd_count
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    TURN    = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_accept;
  logic          w_cs, w_we, w_oe, w_drive;
  logic          r_ready, r_cs, r_we, r_oe, r_drive, r_rsp_valid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;

  // r_ready is only ever set while in IDLE, so it alone qualifies acceptance
  assign w_accept = req_valid & r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_cs    = 1'b1;
    w_we    = 1'b1;
    w_oe    = 1'b1;
    w_drive = 1'b0;
    case (r_state)
      IDLE:    if (w_accept) w_next = req_we ? WR : RD_ADDR;
      WR:      w_next = IDLE;
      RD_ADDR: w_next = RD_DATA;
      RD_DATA: w_next = TURN;
      TURN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Strobes are decoded from the state being entered, then registered
    case (w_next)
      WR: begin
        w_cs    = 1'b0;
        w_we    = 1'b0;
        w_drive = 1'b1;
      end
      RD_ADDR, RD_DATA: begin
        w_cs = 1'b0;
        w_oe = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready     <= 1'b0;
      r_cs        <= 1'b1;
      r_we        <= 1'b1;
      r_oe        <= 1'b1;
      r_drive     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_ready     <= (w_next == IDLE);
      r_cs        <= w_cs;
      r_we        <= w_we;
      r_oe        <= w_oe;
      r_drive     <= w_drive;
      r_rsp_valid <= (r_state == RD_DATA);
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == RD_DATA) r_rdata <= mem_d;
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign mem_a     = r_addr;
  assign mem_cs    = r_cs;
  assign mem_we    = r_we;
  assign mem_oe    = r_oe;
  assign mem_d     = r_drive ? r_wdata : {DW{1'bz}};

`ifdef SRAM_CTRL_STATS_EN
  logic [15:0] r_wr_count, r_rd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_count <= 16'd0;
      r_rd_count <= 16'd0;
    end else begin
      if (r_state == WR && r_wr_count != 16'hFFFF)      r_wr_count <= r_wr_count + 16'd1;
      if (r_state == RD_DATA && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl
// Brief    : randomized self-checking bench for sram_ctrl with an SRAM model
//            and an expected-contents/response-queue reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_a;
  logic          mem_cs, mem_we, mem_oe;
  wire  [DW-1:0] mem_d;
`ifdef SRAM_CTRL_STATS_EN
  logic [15:0]   wr_count, rd_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int n_rsp = 0;
  int cyc = 0;

  sram_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_a(mem_a), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_d(mem_d)
`ifdef SRAM_CTRL_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: write on a write-strobed edge, registered read, drives bus on oe
  logic [DW-1:0] sram [2**AW];
  logic [DW-1:0] sram_q = '0;
  always @(posedge clk) begin
    if (!mem_cs && !mem_we) sram[mem_a] <= mem_d;
    else if (!mem_cs)       sram_q <= sram[mem_a];
  end
  assign mem_d = (!mem_cs && !mem_oe && mem_we) ? sram_q : {DW{1'bz}};
  // A released bus floats to all ones
  pullup (mem_d);

  // Reference: expected memory contents and expected responses with due cycle
  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] exp_q [$];
  int            exp_cyc [$];
  logic          need_gap = 1'b0;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    int            c;
    logic          wr_ph, rd_ph;
    if (rsp_valid) begin
      n_rsp++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_extra: rsp_valid=1 rdata=%h, required no response", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc.pop_front();
        if (rsp_rdata !== e || cyc != c) begin
          miscompares++;
          $display("FAIL rsp_data: got %h at cycle %0d, required %h at cycle %0d", rsp_rdata, cyc, e, c);
        end
      end
    end
    if (rst_n && req_valid && req_ready) begin
      if (req_we) model[req_addr] = req_wdata;
      else begin
        exp_q.push_back(model[req_addr]);
        exp_cyc.push_back(cyc + 3);
      end
    end
    wr_ph = (mem_cs === 1'b0 && mem_we === 1'b0);
    rd_ph = (mem_cs === 1'b0 && mem_we === 1'b1 && mem_oe === 1'b0);
    if (!wr_ph && !rd_ph) begin
      vectors++;
      if (mem_d !== {DW{1'b1}}) begin
        miscompares++;
        $display("FAIL bus_release: mem_d=%h cs/we/oe=%b%b%b, required released bus", mem_d, mem_cs, mem_we, mem_oe);
      end
    end
    if (wr_ph) begin
      vectors++;
      if (need_gap) begin
        miscompares++;
        $display("FAIL turnaround: write strobes with no idle cycle after read, required idle gap");
      end
    end
    if (rd_ph) need_gap = 1'b1;
    else if (mem_cs === 1'b1 && mem_we === 1'b1 && mem_oe === 1'b1) need_gap = 1'b0;
  end

  // Presents a request at posedge+1 and returns at posedge+1 after acceptance
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) begin
      miscompares++;
      $display("FAIL issue_timeout: req_ready=%b, required 1 within 20 cycles", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain;
    int g = 0;
    req_valid = 1'b0;
    while ((exp_q.size() != 0 || req_ready !== 1'b1) && g < 50) begin @(negedge clk); g++; end
    vectors++;
    if (g >= 50) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready, mem_cs, mem_we, mem_oe, rsp_valid} !== 5'b01110) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready/cs/we/oe/rsp=%b, required 01110", {req_ready, mem_cs, mem_we, mem_oe, rsp_valid});
    end
    vectors++;
    if (mem_a !== '0 || rsp_rdata !== '0 || mem_d !== {DW{1'b1}}) begin
      miscompares++;
      $display("FAIL reset_data: mem_a=%h rdata=%h mem_d=%h, required 0 0 ff", mem_a, rsp_rdata, mem_d);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: req_ready=%b one edge after release, required 1", req_ready);
    end
  endtask

  task automatic test_basic;
    logic [2:0]    p;
    logic [4:0]    rp, vp;
    logic [DW-1:0] got = '0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
    @(negedge clk); p[2] = req_ready;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); p[1] = req_ready;
    @(negedge clk); p[0] = req_ready;
    vectors++;
    if (p !== 3'b101) begin
      miscompares++;
      $display("FAIL write_ready_pattern: %b, required 101", p);
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rp[4-i] = req_ready;
      vp[4-i] = rsp_valid;
      if (rsp_valid) got = rsp_rdata;
      if (i == 0) begin @(posedge clk); #1 req_valid = 1'b0; end
    end
    vectors++;
    if (rp !== 5'b10001 || vp !== 5'b00010 || got !== 8'hA5) begin
      miscompares++;
      $display("FAIL read_basic: ready=%b rsp=%b data=%h, required 10001 00010 a5", rp, vp, got);
    end
    @(posedge clk); #1;
    issue(1'b1, 4'd5, 8'h3C);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (rsp_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL rdata_hold: rsp_rdata=%h after a write, required a5", rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    int base = n_rsp;
    for (int a = 0; a < 16; a++) begin
      issue(1'b1, AW'(a), DW'(a) ^ 8'h5A);
      req_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    for (int a = 0; a < 16; a++) begin
      issue(1'b0, AW'(a), '0);
      req_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    vectors++;
    if (n_rsp - base != 16) begin
      miscompares++;
      $display("FAIL fill_count: %0d responses, required 16", n_rsp - base);
    end
  endtask

  task automatic test_back_to_back;
    int base = n_rsp;
    for (int i = 0; i < 40; i++)
      issue(i[0], AW'($urandom_range(0, 15)), DW'($urandom));
    drain();
    vectors++;
    if (n_rsp - base != 20) begin
      miscompares++;
      $display("FAIL b2b_count: %0d responses, required 20", n_rsp - base);
    end
  endtask

  task automatic test_reset_rd;
    int base = n_rsp;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    exp_cyc.delete();
    #1;
    vectors++;
    if ({mem_cs, mem_we, mem_oe} !== 3'b111 || mem_d !== {DW{1'b1}}) begin
      miscompares++;
      $display("FAIL rd_abort_bus: cs/we/oe=%b mem_d=%h, required 111 released", {mem_cs, mem_we, mem_oe}, mem_d);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_abort_ready0: req_ready=%b before first edge, required 0", req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_abort_ready1: req_ready=%b one edge after release, required 1", req_ready);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (n_rsp != base) begin
      miscompares++;
      $display("FAIL rd_abort_rsp: %0d responses, required 0", n_rsp - base);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_wr;
    int            g = 0;
    logic [DW-1:0] got;
    issue(1'b1, 4'd7, 8'h11);
    drain();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7; req_wdata = 8'h99;
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    model[7] = 8'h11;
    #1;
    vectors++;
    if ({mem_cs, mem_we, mem_oe} !== 3'b111) begin
      miscompares++;
      $display("FAIL wr_abort_bus: cs/we/oe=%b, required 111", {mem_cs, mem_we, mem_oe});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 4'd7, '0);
    req_valid = 1'b0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && g < 10) begin @(negedge clk); g++; end
    got = rsp_rdata;
    vectors++;
    if (g >= 10 || got !== 8'h11) begin
      miscompares++;
      $display("FAIL wr_abort_data: read %h (waited %0d), required 11", got, g);
    end
    drain();
  endtask

`ifdef SRAM_CTRL_STATS_EN
  task automatic test_stats;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) issue(1'b1, AW'(i), DW'($urandom));
    for (int i = 0; i < 2; i++) issue(1'b0, AW'(i), '0);
    drain();
    vectors++;
    if (wr_count !== 16'd3 || rd_count !== 16'd2) begin
      miscompares++;
      $display("FAIL stats_count: wr=%0d rd=%0d, required 3 2", wr_count, rd_count);
    end
    @(negedge clk);
    force dut.r_wr_count = 16'hFFFD;
    force dut.r_rd_count = 16'hFFFE;
    #1;
    release dut.r_wr_count;
    release dut.r_rd_count;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), DW'($urandom));
    for (int i = 0; i < 3; i++) issue(1'b0, AW'(i), '0);
    drain();
    vectors++;
    if (wr_count !== 16'hFFFF || rd_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL stats_saturate: wr=%h rd=%h, required ffff ffff", wr_count, rd_count);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      sram[i]  = '0;
      model[i] = '0;
    end
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_reset_rd();
    test_reset_wr();
`ifdef SRAM_CTRL_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
